// File: rtl/pulse_period_meter_if.sv
// ----------------------------------------------------------------------------
// pulse_period_meter_if
//   Groups the strobe input and the measurement results of pulse_period_meter.
//   WIDTH must match the WIDTH of the meter that uses the interface.
//
//   Signals
//     pulse_n_in   active-low strobe under measurement
//     period_out   last measured period in clk_in cycles (WIDTH bits)
//     valid_out    one-cycle strobe: period_out just updated
//     locked_out   last two measured periods were equal
//     timeout_out  no falling edge for TIMEOUT cycles
//
//   Modports
//     master  strobe source / result consumer
//     slave   the meter itself
// ----------------------------------------------------------------------------
interface pulse_period_meter_if #(
  parameter int WIDTH = 28
);
  logic             pulse_n_in;
  logic [WIDTH-1:0] period_out;
  logic             valid_out;
  logic             locked_out;
  logic             timeout_out;

  modport master (
    output pulse_n_in,
    input  period_out,
    input  valid_out,
    input  locked_out,
    input  timeout_out
  );

  modport slave (
    input  pulse_n_in,
    output period_out,
    output valid_out,
    output locked_out,
    output timeout_out
  );
endinterface

// File: rtl/pulse_period_meter.sv
// ----------------------------------------------------------------------------
// pulse_period_meter
//   Measures the period, in clk_in cycles, of a periodic active-low strobe
//   (e.g. the one-cycle-low tick of a clock divider). Each period between two
//   successive falling edges is reported with a one-cycle valid strobe, a lock
//   flag when two consecutive periods match, and a timeout flag when the
//   strobe stops for TIMEOUT cycles.
//
//   Parameters
//     WIDTH    width of the cycle counter and of period_out
//     TIMEOUT  cycles without a falling edge before timeout (>= 2)
//
//   Ports
//     clk_in    system clock, all logic on the rising edge
//     reset     synchronous, active-high reset
//     meter_if  slave modport of pulse_period_meter_if
//               (pulse_n_in in; period_out, valid_out, locked_out,
//                timeout_out out)
//
//   Build option
//     PULSE_SYNC_EN  when defined, pulse_n_in passes through a 2-flop
//                    synchronizer before edge detection (adds 2 cycles of
//                    latency, periods unchanged). When undefined the strobe
//                    must already be synchronous to clk_in.
// ----------------------------------------------------------------------------
module pulse_period_meter #(
  parameter int               WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(1000000)
) (
  input  logic                 clk_in,
  input  logic                 reset,
  pulse_period_meter_if.slave  meter_if
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TIMEOUT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             have_prev_q, have_prev_d;
  logic             prev_q;
  logic             sample;
  logic             fall;

  // --------------------------------------------------------------------------
  // Input path
  // --------------------------------------------------------------------------
`ifdef PULSE_SYNC_EN
  // Both stages reset high so the idle (inactive) level never looks like an
  // edge coming out of reset.
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= meter_if.pulse_n_in;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = meter_if.pulse_n_in;
`endif

  // Previous sample resets high: a strobe that is already low when reset
  // releases counts as a falling edge.
  always_ff @(posedge clk_in) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= sample;
  end

  assign fall = prev_q & ~sample;

  // --------------------------------------------------------------------------
  // State and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      counter_q   <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      have_prev_q <= have_prev_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    period_d    = period_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    have_prev_d = have_prev_q;

    case (state_q)
      ST_IDLE: begin
        // First edge only opens a measurement window.
        if (fall) begin
          counter_d = WIDTH'(1);
          state_d   = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        // A falling edge takes priority over the timeout check, so a period
        // exactly equal to TIMEOUT is still a normal measurement.
        if (fall) begin
          period_d    = counter_q;
          valid_d     = 1'b1;
          locked_d    = have_prev_q & (counter_q == period_q);
          have_prev_d = 1'b1;
          counter_d   = WIDTH'(1);
        end else if (counter_q == TIMEOUT) begin
          // Counter is left saturated at TIMEOUT; period_out keeps its value.
          state_d     = ST_TIMEOUT;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          have_prev_d = 1'b0;
        end else begin
          counter_d = counter_q + WIDTH'(1);
        end
      end

      ST_TIMEOUT: begin
        // have_prev is already clear, so the first period after recovery
        // cannot report lock.
        if (fall) begin
          timeout_d = 1'b0;
          counter_d = WIDTH'(1);
          state_d   = ST_MEASURE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign meter_if.period_out  = period_q;
  assign meter_if.valid_out   = valid_q;
  assign meter_if.locked_out  = locked_q;
  assign meter_if.timeout_out = timeout_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// ----------------------------------------------------------------------------
// tb_pulse_period_meter
//   Two meters share one strobe: inst 0 with TIMEOUT=200 and inst 1 with
//   TIMEOUT=50 (fall-vs-timeout tie when driven with period 50). A
//   timestamp-based reference model predicts every output on every cycle;
//   scenario tasks add explicit expectations on top.
// ----------------------------------------------------------------------------
module tb_pulse_period_meter;

  localparam int W   = 28;
  localparam int TO0 = 200;
  localparam int TO1 = 50;
`ifdef PULSE_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b1;

  always #5 clk = ~clk;

  pulse_period_meter_if #(.WIDTH(W)) if0 ();
  pulse_period_meter_if #(.WIDTH(W)) if1 ();

  assign if0.pulse_n_in = pin;
  assign if1.pulse_n_in = pin;

  pulse_period_meter #(.WIDTH(W), .TIMEOUT(W'(TO0))) dut0 (
    .clk_in   (clk),
    .reset    (rst),
    .meter_if (if0)
  );

  pulse_period_meter #(.WIDTH(W), .TIMEOUT(W'(TO1))) dut1 (
    .clk_in   (clk),
    .reset    (rst),
    .meter_if (if1)
  );

  logic [W+2:0] obs [2];
  assign obs[0] = {if0.valid_out, if0.locked_out, if0.timeout_out, if0.period_out};
  assign obs[1] = {if1.valid_out, if1.locked_out, if1.timeout_out, if1.period_out};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // --------------------------------------------------------------------------
  // Reference model: tracks the time of the last falling edge and derives
  // periods and timeouts from timestamp differences.
  // --------------------------------------------------------------------------
  int to_len [2];
  bit m_dly0, m_dly1, m_prev;
  bit m_meas [2];
  bit m_have [2];
  int m_last_fall [2];
  int m_last_p [2];
  bit e_valid [2];
  bit e_locked [2];
  bit e_timeout [2];
  int e_period [2];

  bit [1:0] stim [$];   // {reset, pin} per cycle

  function automatic logic [W+2:0] expv(input int k);
    return {e_valid[k], e_locked[k], e_timeout[k], W'(e_period[k])};
  endfunction

  task automatic step(input bit r, input bit p);
    bit s;
    int p_len;
    rst = r;
    pin = p;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_dly0 = 1'b1;
      m_dly1 = 1'b1;
      m_prev = 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_meas[k] = 0; m_have[k] = 0; m_last_fall[k] = 0; m_last_p[k] = 0;
        e_valid[k] = 0; e_locked[k] = 0; e_timeout[k] = 0; e_period[k] = 0;
      end
    end else begin
`ifdef PULSE_SYNC_EN
      s = m_dly1;
      m_dly1 = m_dly0;
      m_dly0 = p;
`else
      s = p;
`endif
      for (int k = 0; k < 2; k++) begin
        e_valid[k] = 0;
        if (m_prev && !s) begin
          if (m_meas[k]) begin
            p_len = cyc - m_last_fall[k];
            e_valid[k]  = 1;
            e_period[k] = p_len;
            e_locked[k] = m_have[k] && (p_len == m_last_p[k]);
            m_have[k]   = 1;
            m_last_p[k] = p_len;
          end
          e_timeout[k]   = 0;
          m_meas[k]      = 1;
          m_last_fall[k] = cyc;
        end else if (m_meas[k] && (cyc - m_last_fall[k]) == to_len[k]) begin
          m_meas[k]    = 0;
          m_have[k]    = 0;
          e_timeout[k] = 1;
          e_locked[k]  = 0;
        end
      end
      m_prev = s;
    end
    #1;
  endtask

  // One strobe period: `low` cycles low then high for the rest.
  task automatic push_period(input int n, input int low);
    for (int j = 0; j < n; j++) stim.push_back({1'b0, (j < low) ? 1'b0 : 1'b1});
  endtask

  task automatic push_level(input bit lvl, input int n);
    for (int j = 0; j < n; j++) stim.push_back({1'b0, lvl});
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    step(1, 1);
    step(1, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== '0)
        $display("FAIL reset_state inst=%0d got=%h exp=0", k, obs[k]);
      if (obs[k] !== '0) failures++;
    end
    step(0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== expv(k)) begin
        failures++;
        $display("FAIL reset_idle inst=%0d got=%h exp=%h", k, obs[k], expv(k));
      end
    end
    $display("test_reset done cycle=%0d", cyc);
  endtask

  task automatic test_lock_div50();
    int fq [$];
    int nv;
    bit lp, to1_seen;
    step(1, 1);
    stim.delete();
    for (int j = 0; j < 4; j++) push_period(50, 1);
    nv = 0; lp = 1; to1_seen = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      if (lp && !stim[i][0]) fq.push_back(cyc);
      lp = stim[i][0];
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL lock_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if1.timeout_out) to1_seen = 1;
      if (if0.valid_out) begin
        checks++;
        if (if0.period_out !== W'(50)) begin
          failures++;
          $display("FAIL lock_period got=%0d exp=50", if0.period_out);
        end
        checks++;
        if (if0.locked_out !== (nv > 0)) begin
          failures++;
          $display("FAIL lock_flag valid#%0d got=%b exp=%b", nv, if0.locked_out, nv > 0);
        end
        checks++;
        if (nv + 1 >= fq.size() || (cyc - fq[nv + 1]) != EXTRA) begin
          failures++;
          $display("FAIL lock_latency valid#%0d cycle=%0d exp_extra=%0d", nv, cyc, EXTRA);
        end
        $display("valid period=%0d locked=%b cycle=%0d", if0.period_out, if0.locked_out, cyc);
        nv++;
      end
    end
    checks++;
    if (nv != 3) begin
      failures++;
      $display("FAIL lock_count got=%0d exp=3", nv);
    end
    checks++;
    if (to1_seen !== 1'b0) begin
      failures++;
      $display("FAIL tie_timeout got=1 exp=0");
    end
  endtask

  task automatic test_period_switch();
    int nv;
    step(1, 1);
    stim.delete();
    for (int j = 0; j < 3; j++) push_period(50, 1);
    for (int j = 0; j < 3; j++) push_period(10, 1);
    push_period(3, 1);
    nv = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL switch_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.valid_out) begin
        if (nv == 3 || nv == 4) begin
          checks++;
          if (if0.period_out !== W'(10) || if0.locked_out !== (nv == 4)) begin
            failures++;
            $display("FAIL switch_valid valid#%0d got=%0d/%b exp=10/%b", nv, if0.period_out, if0.locked_out, nv == 4);
          end
        end
        $display("valid period=%0d locked=%b cycle=%0d", if0.period_out, if0.locked_out, cyc);
        nv++;
      end
    end
    checks++;
    if (nv != 6) begin
      failures++;
      $display("FAIL switch_count got=%0d exp=6", nv);
    end
  endtask

  task automatic test_timeout();
    int last_fall, to_cyc, nv;
    bit lp;
    step(1, 1);
    stim.delete();
    push_period(30, 1);
    push_period(30, 1);
    push_period(1, 1);
    push_level(1, 210);
    lp = 1; last_fall = 0; to_cyc = -1;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      if (lp && !stim[i][0]) last_fall = cyc;
      lp = stim[i][0];
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL timeout_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.timeout_out && to_cyc < 0) to_cyc = cyc;
    end
    checks++;
    if (to_cyc != last_fall + TO0 + EXTRA) begin
      failures++;
      $display("FAIL timeout_time got=%0d exp=%0d", to_cyc, last_fall + TO0 + EXTRA);
    end
    checks++;
    if ({if0.timeout_out, if0.locked_out, if0.period_out} !== {1'b1, 1'b0, W'(30)}) begin
      failures++;
      $display("FAIL timeout_hold got=%b/%b/%0d exp=1/0/30", if0.timeout_out, if0.locked_out, if0.period_out);
    end
    $display("timeout asserted cycle=%0d period=%0d", to_cyc, if0.period_out);
    stim.delete();
    push_period(30, 1);
    push_period(6, 1);
    nv = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL recover_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.valid_out) begin
        nv++;
        checks++;
        if (if0.locked_out !== 1'b0 || if0.period_out !== W'(30)) begin
          failures++;
          $display("FAIL recover_valid got=%b/%0d exp=0/30", if0.locked_out, if0.period_out);
        end
      end
    end
    checks++;
    if (nv != 1 || if0.timeout_out !== 1'b0) begin
      failures++;
      $display("FAIL recover_state valids=%0d timeout=%b exp=1/0", nv, if0.timeout_out);
    end
  endtask

  task automatic test_toggle();
    int nv;
    step(1, 1);
    stim.delete();
    for (int j = 0; j < 10; j++) push_period(2, 1);
    nv = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL toggle_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.valid_out) begin
        checks++;
        if (if0.period_out !== W'(2) || if0.locked_out !== (nv > 0)) begin
          failures++;
          $display("FAIL toggle_valid valid#%0d got=%0d/%b exp=2/%b", nv, if0.period_out, if0.locked_out, nv > 0);
        end
        nv++;
      end
    end
    $display("toggle valids=%0d", nv);
  endtask

  task automatic test_reset_mid();
    int nv;
    step(1, 1);
    stim.delete();
    push_period(50, 1);
    push_period(20, 1);
    stim.push_back(2'b11);
    foreach (stim[i]) step(stim[i][1], stim[i][0]);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== '0) begin
        failures++;
        $display("FAIL midreset_zero inst=%0d got=%h exp=0", k, obs[k]);
      end
    end
    stim.delete();
    push_level(1, 5);
    push_period(25, 1);
    push_period(6, 1);
    nv = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL midreset_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.valid_out) begin
        nv++;
        checks++;
        if (if0.period_out !== W'(25)) begin
          failures++;
          $display("FAIL midreset_period got=%0d exp=25", if0.period_out);
        end
      end
    end
    checks++;
    if (nv != 1) begin
      failures++;
      $display("FAIL midreset_count got=%0d exp=1", nv);
    end
  endtask

  task automatic test_hold_low();
    int nv, nto;
    bit last_to;
    step(1, 1);
    stim.delete();
    push_level(0, 300);
    nv = 0; nto = 0; last_to = 0;
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL holdlow_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
      if (if0.valid_out) nv++;
      if (if0.timeout_out && !last_to) nto++;
      last_to = if0.timeout_out;
    end
    checks++;
    if (nv != 0 || nto != 1) begin
      failures++;
      $display("FAIL holdlow_counts valids=%0d timeouts=%0d exp=0/1", nv, nto);
    end
  endtask

  task automatic test_random();
    int n;
    step(1, 1);
    stim.delete();
    for (int j = 0; j < 40; j++) begin
      n = $urandom_range(60, 2);
      push_period(n, $urandom_range(n - 1, 1));
      if ($urandom_range(7, 0) == 0) push_level(1, $urandom_range(260, 40));
      if ($urandom_range(14, 0) == 0) stim.push_back({1'b1, 1'($urandom_range(1, 0))});
    end
    foreach (stim[i]) begin
      step(stim[i][1], stim[i][0]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== expv(k)) begin
          failures++;
          $display("FAIL random_cycle cycle=%0d inst=%0d got=%h exp=%h", cyc, k, obs[k], expv(k));
        end
      end
    end
    $display("random cycles=%0d", stim.size());
  endtask

  initial begin
    to_len[0] = TO0;
    to_len[1] = TO1;
    test_reset();
    test_lock_div50();
    test_period_switch();
    test_timeout();
    test_toggle();
    test_reset_mid();
    test_hold_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
